// File: rtl/dl_shift_seq_if.sv
// Request/response bundle for dl_shift_seq.
// slave: the sequencer side; master: the requester/consumer side.
interface dl_shift_seq_if #(
  parameter int NUM_BITS = 32
);
  localparam int SHW = $clog2(NUM_BITS);

  logic                req_valid;
  logic                req_ready;
  logic [NUM_BITS-1:0] req_data;
  logic [SHW-1:0]      req_shamt;
  logic [1:0]          req_op;
  logic                resp_valid;
  logic                resp_ready;
  logic [NUM_BITS-1:0] resp_data;

  modport slave (
    input  req_valid, req_data, req_shamt, req_op, resp_ready,
    output req_ready, resp_valid, resp_data
  );

  modport master (
    output req_valid, req_data, req_shamt, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/dl_shift_seq.sv
// Multi-cycle shift sequencer: SLL/SRL/SRA of a NUM_BITS operand, at most
// STEP positions per cycle through one small shift stage.
// Optional feature macro: DL_SHIFT_SEQ_ABORT_EN (adds the abort input).
module dl_shift_seq #(
  parameter int NUM_BITS = 32,
  parameter int STEP     = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef DL_SHIFT_SEQ_ABORT_EN
  input  logic abort,
`endif
  dl_shift_seq_if.slave bus,
  output logic busy
);
  localparam int SHW = $clog2(NUM_BITS);
  localparam logic [SHW-1:0]      STEP_W = SHW'(STEP);
  localparam logic [NUM_BITS-1:0] ONES   = {NUM_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] work_q, work_d;
  logic [SHW-1:0]      rem_q, rem_d;
  logic                right_q, right_d;
  logic                arith_q, arith_d;
  logic                sign_q, sign_d;

  logic [SHW-1:0]      k;
  logic [SHW-1:0]      rem_nxt;
  logic [NUM_BITS-1:0] fill;
  logic [NUM_BITS-1:0] shifted;

  // Single shift stage: k = min(remaining, STEP); SRA fills with the
  // operand MSB captured at accept time, logical shifts fill with zero.
  always_comb begin
    k       = (rem_q > STEP_W) ? STEP_W : rem_q;
    rem_nxt = rem_q - k;
    fill    = (right_q && arith_q && sign_q) ? ~(ONES >> k) : '0;
    shifted = right_q ? ((work_q >> k) | fill) : (work_q << k);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    right_d = right_q;
    arith_d = arith_q;
    sign_d  = sign_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          work_d  = bus.req_data;
          rem_d   = bus.req_shamt;
          right_d = bus.req_op[0];
          // arithmetic only meaningful for right shifts; 2'b10 is SLL
          arith_d = bus.req_op[1] & bus.req_op[0];
          sign_d  = bus.req_data[NUM_BITS-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_nxt;
        if (rem_nxt == '0) state_d = DONE;
      end
      DONE: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef DL_SHIFT_SEQ_ABORT_EN
    // Abort cancels any in-flight op; coinciding with a DONE handshake it
    // lands in IDLE as well, so the consumed result is unaffected.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      rem_d   = '0;
    end
`endif
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      right_q <= right_d;
      arith_q <= arith_d;
      sign_q  <= sign_d;
    end
  end

  // Handshake outputs decode from state only (no combinational path from
  // req_valid/resp_ready).
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == DONE);
  assign bus.resp_data  = work_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_dl_shift_seq.sv
// Self-checking bench for dl_shift_seq (NUM_BITS=8, STEP=2), directed and
// randomized ops against a one-shot shift reference model.
module tb_dl_shift_seq;
  localparam int NB = 8;
  localparam int ST = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic abort = 1'b0;
  int   errors = 0;
  int   checks = 0;

  dl_shift_seq_if #(.NUM_BITS(NB)) bus ();

  dl_shift_seq #(.NUM_BITS(NB), .STEP(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef DL_SHIFT_SEQ_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus.slave),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference: the whole shift at once.
  function automatic logic [NB-1:0] ref_shift(input logic [NB-1:0] d,
                                              input logic [2:0] sh,
                                              input logic [1:0] op);
    if (!op[0])     return d << sh;
    else if (op[1]) return NB'($signed(d) >>> sh);
    else            return d >> sh;
  endfunction

  function automatic int ref_lat(input logic [2:0] sh);
    if (sh == 0) return 1;
    return (int'(sh) + ST - 1) / ST;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One transaction: accept, count cycles to resp_valid, hold the response
  // `hold` cycles under backpressure, then handshake.
  task automatic do_op(input logic [NB-1:0] d, input logic [2:0] sh,
                       input logic [1:0] op, input int hold, input string nm);
    logic [NB-1:0] exp_d;
    logic [NB-1:0] first;
    int cnt;
    exp_d = ref_shift(d, sh, op);
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready_idle got=%b want=1", nm, bus.req_ready);
    end
    bus.req_valid = 1'b1; bus.req_data = d; bus.req_shamt = sh; bus.req_op = op;
    step();
    bus.req_valid = 1'b0; bus.req_data = $urandom; bus.req_shamt = 3'($urandom);
    checks++;
    if (bus.req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s shift_flags req_ready=%b busy=%b want 0/1", nm, bus.req_ready, busy);
    end
    cnt = 0;
    while (bus.resp_valid !== 1'b1 && cnt < 40) begin
      step(); cnt++;
    end
    checks++;
    if (cnt != ref_lat(sh)) begin
      errors++; $display("FAIL %s latency got=%0d want=%0d", nm, cnt, ref_lat(sh));
    end
    checks++;
    if (bus.resp_data !== exp_d) begin
      errors++; $display("FAIL %s data got=%h want=%h", nm, bus.resp_data, exp_d);
    end
    first = bus.resp_data;
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== first ||
          bus.req_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s hold%0d valid=%b data=%h req_ready=%b busy=%b want 1/%h/0/1",
                 nm, i, bus.resp_valid, bus.resp_data, bus.req_ready, busy, first);
      end
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_hs req_ready=%b resp_valid=%b busy=%b want 1/0/0",
               nm, bus.req_ready, bus.resp_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.resp_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset req_ready=%b resp_valid=%b data=%h busy=%b want 1/0/00/0",
               bus.req_ready, bus.resp_valid, bus.resp_data, busy);
    end
  endtask

  task automatic test_directed();
    do_op(8'h80, 3'd7, 2'b11, 0, "sra_80_7");
    do_op(8'h01, 3'd3, 2'b00, 0, "sll_01_3");
    do_op(8'h80, 3'd7, 2'b01, 0, "srl_80_7");
    do_op(8'h81, 3'd1, 2'b10, 0, "op10_81_1");
    do_op(8'hC3, 3'd2, 2'b11, 0, "sra_c3_2");
  endtask

  task automatic test_zero_shamt();
    do_op(8'hA5, 3'd0, 2'b11, 0, "zero_sra");
    do_op(8'hA5, 3'd0, 2'b00, 0, "zero_sll");
  endtask

  task automatic test_back_to_back();
    do_op(8'h3C, 3'd5, 2'b01, 5, "bp_srl");
    do_op(8'h96, 3'd4, 2'b11, 0, "bp_next");
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.req_valid = 1'b1; bus.req_data = 8'h80; bus.req_shamt = 3'd7; bus.req_op = 2'b11;
    step();
    bus.req_valid = 1'b0;
    step();               // second SHIFT cycle
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.resp_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid req_ready=%b resp_valid=%b data=%h busy=%b want 1/0/00/0",
               bus.req_ready, bus.resp_valid, bus.resp_data, busy);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.resp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rst_mid_noresp got=%0d responses want=0", seen);
    end
  endtask

`ifdef DL_SHIFT_SEQ_ABORT_EN
  task automatic test_abort();
    int seen;
    bus.req_valid = 1'b1; bus.req_data = 8'h80; bus.req_shamt = 3'd7; bus.req_op = 2'b11;
    step();
    bus.req_valid = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort req_ready=%b resp_valid=%b busy=%b want 1/0/0",
               bus.req_ready, bus.resp_valid, busy);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.resp_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_noresp got=%0d responses want=0", seen);
    end
    do_op(8'hF0, 3'd4, 2'b01, 0, "post_abort_srl");
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      do_op(NB'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), "rand");
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_data = '0; bus.req_shamt = '0;
    bus.req_op = 2'b00; bus.resp_ready = 1'b0;
    test_reset();
    test_directed();
    test_zero_shamt();
    test_back_to_back();
    test_reset_mid();
`ifdef DL_SHIFT_SEQ_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
